axis_rr_arbiter: RTL and testbench
==================================

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 16, beat data width in bits (multiple of 8).
REQ-002 Parameter N_SRC, 4, number of upstream AXI-Stream sources (2..8).
REQ-003 ACLK  input  1  single clock; all logic on rising edge.
REQ-004 ARESETn  input  1  reset, asynchronous, active-low.
REQ-005 S_TVALID  input  N_SRC  per-source beat valid.
REQ-006 S_TREADY  output  N_SRC  per-source beat ready.
REQ-007 S_TDATA  input  N_SRC*DATA_WIDTH  per-source data, source i at slice i.
REQ-008 S_TKEEP  input  N_SRC*(DATA_WIDTH/8)  per-source byte keep.
REQ-009 S_TLAST  input  N_SRC  per-source end of packet.
REQ-010 S_TUSER  input  N_SRC*2  per-source sideband.
REQ-011 S_TDEST  input  N_SRC*8  per-source destination.
REQ-012 M_TVALID  output  1  merged beat valid.
REQ-013 M_TREADY  input  1  downstream ready.
REQ-014 M_TDATA / M_TKEEP / M_TLAST / M_TUSER / M_TDEST  output  DATA_WIDTH / DATA_WIDTH/8 / 1 / 2 / 8  merged beat fields.
REQ-015 M_TID  output  clog2(N_SRC)  index of the source that supplied the beat.
REQ-016 BUSY  output  1  high while a grant is held (state PASS).
REQ-017 PKT_CNT  output  16  count of completed packets forwarded.

Function
REQ-018 The FSM SHALL have two states: IDLE (no grant) and PASS (one source granted).
REQ-019 In IDLE with any S_TVALID high, the block SHALL register a grant to the first requesting index at or after rr_ptr, wrapping modulo N_SRC, and enter PASS on the next edge.
REQ-020 In IDLE with no S_TVALID high, the block SHALL remain in IDLE with the grant unchanged.
REQ-021 S_TREADY[g] SHALL be (state==PASS) & (~M_TVALID | M_TREADY) for granted index g; all other S_TREADY bits SHALL be 0.
REQ-022 A source beat is accepted when S_TVALID[g] & S_TREADY[g]; its fields and M_TID=g SHALL be registered into the output stage with M_TVALID=1 on the same edge.
REQ-023 The output register SHALL hold the beat stable with M_TVALID=1 until M_TREADY=1; M_TVALID SHALL clear on an M_TREADY edge when no new beat is accepted.
REQ-024 Latency: a request in IDLE at cycle 0 gives a grant at cycle 1; the first beat appears on M_* at cycle 2 when downstream is ready.
REQ-025 Throughput in PASS SHALL be one beat per cycle while S_TVALID[g] and M_TREADY are both high.
REQ-026 Acceptance of a beat with S_TLAST[g]=1 SHALL move the FSM to IDLE, set rr_ptr=(g+1) mod N_SRC, and increment PKT_CNT on the same edge.
REQ-027 PKT_CNT SHALL wrap from 0xFFFF to 0x0000.
REQ-028 The grant SHALL be held through source stalls (S_TVALID[g] low mid-packet); no timeout and no pre-emption.
REQ-029 Requests from non-granted sources SHALL neither stall nor alter the active packet.
REQ-030 After the last beat, at least one IDLE cycle SHALL occur before the next grant, even with simultaneous requests.
REQ-031 The granted source's S_TVALID SHALL be ignored in IDLE cycles only for arbitration order; fairness SHALL ensure each continuously requesting source is granted within N_SRC packets.

Reset
REQ-032 ARESETn low SHALL, asynchronously: set state=IDLE, rr_ptr=0, grant=0, M_TVALID=0, M_TLAST=0, M_TDATA/M_TKEEP/M_TUSER/M_TDEST/M_TID=0, PKT_CNT=0, BUSY=0; S_TREADY=0.
REQ-033 Reset asserted mid-packet SHALL drop the in-flight beat; after release the block SHALL start in IDLE and re-arbitrate from index 0.

Verification
REQ-034 Single source: src1 sends 3 beats 0x0A01,0x0A02,0x0A03 (last on third), M_TREADY=1 -> M_TDATA sequence matches, M_TID=1, first beat at cycle 2, PKT_CNT=1.
REQ-035 All four request continuously with 2-beat packets -> grant order 0,1,2,3,0; PKT_CNT=5 after five packets.
REQ-036 Backpressure: M_TREADY toggles 1,0,0,1 during a packet -> M_TDATA held stable while M_TREADY=0, no beat lost or duplicated.
REQ-037 Source stall: src2 drops S_TVALID for 3 cycles mid-packet while src0 requests -> BUSY stays 1, M_TID stays 2, src0 granted only after src2 TLAST.
REQ-038 Reset mid-packet: ARESETn low during beat 2 of 4 -> M_TVALID=0 immediately, PKT_CNT=0; after release src3 request granted first-from-0 order.
REQ-039 Wrap: preload 0xFFFF completions, one more packet -> PKT_CNT=0x0000.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
//   Packet-level round-robin merge of N_SRC AXI-Stream sources onto one
//   AXI-Stream master. A grant is taken in IDLE, held for a whole packet
//   (through source stalls, no pre-emption) and released on the accepted
//   TLAST beat. The next search then starts one past the source that just
//   finished. The merged beat sits in a single output register.
//
// Ports
//   ACLK, ARESETn        clock, asynchronous active-low reset
//   S_TVALID/S_TREADY    per-source handshake (N_SRC bits)
//   S_TDATA/TKEEP/TLAST/TUSER/TDEST
//                        per-source beat fields, source i in slice i
//   M_TVALID/M_TREADY    merged handshake
//   M_TDATA/TKEEP/TLAST/TUSER/TDEST
//                        merged beat fields (registered)
//   M_TID                index of the source that supplied the beat
//   BUSY                 high while a grant is held
//   PKT_CNT              completed packets forwarded (wraps at 16 bits)
// ---------------------------------------------------------------------------
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int N_SRC      = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,
  input  logic [N_SRC-1:0]                  S_TVALID,
  output logic [N_SRC-1:0]                  S_TREADY,
  input  logic [N_SRC*DATA_WIDTH-1:0]       S_TDATA,
  input  logic [N_SRC*(DATA_WIDTH/8)-1:0]   S_TKEEP,
  input  logic [N_SRC-1:0]                  S_TLAST,
  input  logic [N_SRC*2-1:0]                S_TUSER,
  input  logic [N_SRC*8-1:0]                S_TDEST,
  output logic                              M_TVALID,
  input  logic                              M_TREADY,
  output logic [DATA_WIDTH-1:0]             M_TDATA,
  output logic [DATA_WIDTH/8-1:0]           M_TKEEP,
  output logic                              M_TLAST,
  output logic [1:0]                        M_TUSER,
  output logic [7:0]                        M_TDEST,
  output logic [$clog2(N_SRC)-1:0]          M_TID,
  output logic                              BUSY,
  output logic [15:0]                       PKT_CNT
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int ID_W   = $clog2(N_SRC);

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     grant;
  logic [ID_W-1:0]     rr_ptr;
  logic [15:0]         pkt_cnt;

  logic                m_tvalid_q;
  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic [KEEP_W-1:0]   m_tkeep_q;
  logic                m_tlast_q;
  logic [1:0]          m_tuser_q;
  logic [7:0]          m_tdest_q;
  logic [ID_W-1:0]     m_tid_q;

  logic                pick_vld;
  logic [ID_W-1:0]     pick_idx;
  logic                out_free;
  logic                accept;
  logic [ID_W-1:0]     ptr_after;

  logic                  sel_vld;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_W-1:0]     sel_keep;
  logic                  sel_last;
  logic [1:0]            sel_user;
  logic [7:0]            sel_dest;

  // Rotated priority search. Walking the offsets downwards lets the smallest
  // offset from rr_ptr overwrite any larger one, giving "first at or after".
  always_comb begin
    int cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = rr_ptr;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_SRC) cand = cand - N_SRC;
      if (S_TVALID[ID_W'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = ID_W'(cand);
      end
    end
  end

  // Field mux for the granted source
  always_comb begin
    sel_vld  = 1'b0;
    sel_data = '0;
    sel_keep = '0;
    sel_last = 1'b0;
    sel_user = '0;
    sel_dest = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant == ID_W'(i)) begin
        sel_vld  = S_TVALID[i];
        sel_data = S_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep = S_TKEEP[i*KEEP_W +: KEEP_W];
        sel_last = S_TLAST[i];
        sel_user = S_TUSER[i*2 +: 2];
        sel_dest = S_TDEST[i*8 +: 8];
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign out_free  = ~m_tvalid_q | M_TREADY;
  assign accept    = (state == PASS) & out_free & sel_vld;
  assign ptr_after = (grant == ID_W'(N_SRC - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    S_TREADY = '0;
    for (int i = 0; i < N_SRC; i++) begin
      S_TREADY[i] = (state == PASS) & out_free & (grant == ID_W'(i));
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      pkt_cnt    <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= '0;
      m_tdest_q  <= '0;
      m_tid_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick_idx;
            state <= PASS;
          end
        end
        PASS: begin
          // Dropping to IDLE on TLAST forces one arbitration cycle between
          // packets, so the rotated pointer is always honoured.
          if (accept && sel_last) begin
            state   <= IDLE;
            rr_ptr  <= ptr_after;
            pkt_cnt <= pkt_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= sel_data;
        m_tkeep_q  <= sel_keep;
        m_tlast_q  <= sel_last;
        m_tuser_q  <= sel_user;
        m_tdest_q  <= sel_dest;
        m_tid_q    <= grant;
      end else if (M_TREADY) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign M_TVALID = m_tvalid_q;
  assign M_TDATA  = m_tdata_q;
  assign M_TKEEP  = m_tkeep_q;
  assign M_TLAST  = m_tlast_q;
  assign M_TUSER  = m_tuser_q;
  assign M_TDEST  = m_tdest_q;
  assign M_TID    = m_tid_q;
  assign BUSY     = (state == PASS);
  assign PKT_CNT  = pkt_cnt;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_rr_arbiter
//   Drives per-source packet queues into axis_rr_arbiter and compares every
//   cycle against a packet-level round-robin reference, then runs directed
//   scenarios with literal expectations and a randomized soak.
// ---------------------------------------------------------------------------
module tb_axis_rr_arbiter;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int KW = DW / 8;
  localparam int IW = 2;

  logic               ACLK = 1'b0;
  logic               ARESETn = 1'b0;
  logic [N-1:0]       S_TVALID;
  logic [N-1:0]       S_TREADY;
  logic [N*DW-1:0]    S_TDATA;
  logic [N*KW-1:0]    S_TKEEP;
  logic [N-1:0]       S_TLAST;
  logic [N*2-1:0]     S_TUSER;
  logic [N*8-1:0]     S_TDEST;
  logic               M_TVALID;
  logic               M_TREADY;
  logic [DW-1:0]      M_TDATA;
  logic [KW-1:0]      M_TKEEP;
  logic               M_TLAST;
  logic [1:0]         M_TUSER;
  logic [7:0]         M_TDEST;
  logic [IW-1:0]      M_TID;
  logic               BUSY;
  logic [15:0]        PKT_CNT;

  always #5 ACLK = ~ACLK;

  axis_rr_arbiter #(.DATA_WIDTH(DW), .N_SRC(N)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA),
    .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST), .S_TUSER(S_TUSER), .S_TDEST(S_TDEST),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
    .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST), .M_TUSER(M_TUSER), .M_TDEST(M_TDEST),
    .M_TID(M_TID), .BUSY(BUSY), .PKT_CNT(PKT_CNT)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        last;
    logic [1:0]  user;
    logic [7:0]  dest;
    logic [3:0]  gap;
  } beat_t;

  typedef struct {
    logic [15:0] data;
    int          id;
    logic        last;
    int          t;
  } ob_t;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    mt_mode = 0;
  logic  chk_en = 1'b0;
  logic  preload = 1'b0;

  beat_t        q [N][$];
  beat_t        cur [N];
  logic [N-1:0] cur_vld;
  logic [N-1:0] hs;
  int           gap_cnt [N];
  ob_t          log_q [$];

  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, a, e, cyc);
    end
  endfunction

  function automatic logic bit_at(logic [N-1:0] v, int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic beat_t mk(logic [15:0] d, logic last, int gap);
    beat_t b;
    b.data = d;
    b.keep = 2'($urandom);
    b.user = 2'($urandom);
    b.dest = 8'($urandom);
    b.last = last;
    b.gap  = 4'(gap);
    return b;
  endfunction

  // Fields presented by source i on the input bus
  function automatic beat_t src_beat(int i);
    beat_t b;
    logic [N*DW-1:0] d;
    logic [N*KW-1:0] k;
    logic [N*2-1:0]  u;
    logic [N*8-1:0]  ds;
    d = S_TDATA >> (i * DW);
    k = S_TKEEP >> (i * KW);
    u = S_TUSER >> (i * 2);
    ds = S_TDEST >> (i * 8);
    b.data = d[DW-1:0];
    b.keep = k[KW-1:0];
    b.user = u[1:0];
    b.dest = ds[7:0];
    b.last = bit_at(S_TLAST, i);
    b.gap  = '0;
    return b;
  endfunction

  // First requester at or after ptr, going round modulo N
  function automatic int pick(int ptr, logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (bit_at(v, (ptr + k) % N)) return (ptr + k) % N;
    return ptr;
  endfunction

  // ---------------- reference model ----------------
  logic        mb;
  int          mg, mptr, oid;
  logic        ov, ol;
  logic [15:0] od, mc;
  logic [1:0]  okp, ou;
  logic [7:0]  odst;
  beat_t       m_in;

  always_comb m_in = src_beat(mg);

  function automatic logic m_room();
    return mb && (!ov || M_TREADY);
  endfunction

  function automatic logic m_take();
    return m_room() && bit_at(S_TVALID, mg);
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    logic [N-1:0] one;
    one = 1;
    if (m_room()) return one << mg;
    return '0;
  endfunction

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      mb <= 1'b0; mg <= 0; mptr <= 0; ov <= 1'b0; ol <= 1'b0;
      od <= '0; okp <= '0; ou <= '0; odst <= '0; oid <= 0; mc <= '0;
    end else begin
      if (m_take()) begin
        ov <= 1'b1; od <= m_in.data; okp <= m_in.keep; ol <= m_in.last;
        ou <= m_in.user; odst <= m_in.dest; oid <= mg;
      end else if (M_TREADY) begin
        ov <= 1'b0;
      end
      if (preload) mc <= 16'hFFFF;
      if (!mb) begin
        if (S_TVALID != '0) begin
          mg <= pick(mptr, S_TVALID);
          mb <= 1'b1;
        end
      end else if (m_take() && m_in.last) begin
        mb   <= 1'b0;
        mptr <= (mg + 1) % N;
        mc   <= mc + 16'd1;
      end
    end
  end

  // ---------------- compare + output log ----------------
  initial begin
    forever begin
      @(negedge ACLK);
      #2;
      if (chk_en) begin
        chk("M_TVALID", 64'(M_TVALID), 64'(ov));
        chk("M_TDATA",  64'(M_TDATA),  64'(od));
        chk("M_TKEEP",  64'(M_TKEEP),  64'(okp));
        chk("M_TLAST",  64'(M_TLAST),  64'(ol));
        chk("M_TUSER",  64'(M_TUSER),  64'(ou));
        chk("M_TDEST",  64'(M_TDEST),  64'(odst));
        chk("M_TID",    64'(M_TID),    64'(oid));
        chk("BUSY",     64'(BUSY),     64'(mb));
        chk("PKT_CNT",  64'(PKT_CNT),  64'(mc));
        chk("S_TREADY", 64'(S_TREADY), 64'(exp_rdy()));
      end
      if (M_TVALID && M_TREADY)
        log_q.push_back('{data: M_TDATA, id: int'(M_TID), last: M_TLAST, t: cyc});
    end
  end

  // ---------------- source / sink driver ----------------
  initial begin
    beat_t h;
    logic [3:0] pat;
    pat = 4'b1001;
    S_TVALID = '0; S_TDATA = '0; S_TKEEP = '0; S_TLAST = '0;
    S_TUSER = '0; S_TDEST = '0; M_TREADY = 1'b1;
    cur_vld = '0; hs = '0;
    for (int i = 0; i < N; i++) begin
      gap_cnt[i] = 0;
      cur[i] = '0;
    end
    forever begin
      @(negedge ACLK);
      for (int i = 0; i < N; i++) begin
        if (!ARESETn) begin
          cur_vld[i] = 1'b0;
          gap_cnt[i] = 0;
        end else begin
          if (cur_vld[i] && hs[i]) cur_vld[i] = 1'b0;
          if (!cur_vld[i] && q[i].size() > 0) begin
            h = q[i][0];
            if (gap_cnt[i] < int'(h.gap)) gap_cnt[i]++;
            else begin
              cur[i] = q[i].pop_front();
              cur_vld[i] = 1'b1;
              gap_cnt[i] = 0;
            end
          end
        end
        S_TVALID[i]            = cur_vld[i];
        S_TDATA[i*DW +: DW]    = cur[i].data;
        S_TKEEP[i*KW +: KW]    = cur[i].keep;
        S_TLAST[i]             = cur[i].last;
        S_TUSER[i*2 +: 2]      = cur[i].user;
        S_TDEST[i*8 +: 8]      = cur[i].dest;
      end
      case (mt_mode)
        1:       M_TREADY = bit_at(pat, cyc % 4);
        2:       M_TREADY = ($urandom_range(0, 3) != 0);
        default: M_TREADY = 1'b1;
      endcase
      #3;
      hs = S_TVALID & S_TREADY;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    ARESETn = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    #1;
    chk("rst M_TVALID", 64'(M_TVALID), 64'd0);
    chk("rst M_TDATA",  64'(M_TDATA),  64'd0);
    chk("rst M_TID",    64'(M_TID),    64'd0);
    chk("rst BUSY",     64'(BUSY),     64'd0);
    chk("rst PKT_CNT",  64'(PKT_CNT),  64'd0);
    chk("rst S_TREADY", 64'(S_TREADY), 64'd0);
    repeat (2) @(negedge ACLK);
    #1;
    ARESETn = 1'b1;
    log_q.delete();
  endtask

  task automatic wait_log(int n, int budget);
    int c;
    c = 0;
    while (log_q.size() < n && c < budget) begin
      @(negedge ACLK);
      #3;
      c++;
    end
    chk("beats within budget", 64'(log_q.size() >= n), 64'd1);
  endtask

  task automatic push_pkt(int src, logic [15:0] base, int len, int gap_at, int gap);
    for (int b = 0; b < len; b++)
      q[src].push_back(mk(base + 16'(b), (b == len - 1), (b == gap_at) ? gap : 0));
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int base;
    int fid [$];
    int exp_ord [5];
    int exp_id [6];
    exp_ord = '{0, 1, 2, 3, 0};
    exp_id  = '{2, 2, 2, 2, 2, 0};

    #1;
    do_reset();
    chk_en = 1'b1;

    // single source, three beats
    mt_mode = 0;
    push_pkt(1, 16'h0A01, 3, -1, 0);
    @(negedge ACLK);
    base = cyc;
    wait_log(3, 40);
    if (log_q.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("single data%0d", k), 64'(log_q[k].data), 64'(16'h0A01 + 16'(k)));
        chk($sformatf("single id%0d", k), 64'(log_q[k].id), 64'd1);
      end
      chk("single first-beat cycle", 64'(log_q[0].t - base), 64'd2);
    end
    repeat (3) @(negedge ACLK);
    #1;
    chk("single PKT_CNT", 64'(PKT_CNT), 64'd1);

    // all four request, 2-beat packets
    #1;
    do_reset();
    push_pkt(0, 16'h1000, 2, -1, 0);
    push_pkt(0, 16'h1010, 2, -1, 0);
    push_pkt(1, 16'h1100, 2, -1, 0);
    push_pkt(2, 16'h1200, 2, -1, 0);
    push_pkt(3, 16'h1300, 2, -1, 0);
    wait_log(10, 200);
    fid.delete();
    foreach (log_q[k])
      if (k == 0 || log_q[k-1].last) fid.push_back(log_q[k].id);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr order %0d", i), 64'((fid.size() > i) ? fid[i] : -1), 64'(exp_ord[i]));
    repeat (5) @(negedge ACLK);
    #1;
    chk("rr PKT_CNT", 64'(PKT_CNT), 64'd5);

    // backpressure pattern 1,0,0,1
    #1;
    do_reset();
    mt_mode = 1;
    push_pkt(0, 16'hB001, 4, -1, 0);
    wait_log(4, 100);
    repeat (10) @(negedge ACLK);
    #3;
    chk("bp beat count", 64'(log_q.size()), 64'd4);
    if (log_q.size() >= 4)
      for (int k = 0; k < 4; k++)
        chk($sformatf("bp data%0d", k), 64'(log_q[k].data), 64'(16'hB001 + 16'(k)));
    mt_mode = 0;

    // source stall, grant held while src0 waits
    #1;
    do_reset();
    push_pkt(2, 16'hC001, 5, 2, 3);
    repeat (2) @(negedge ACLK);
    #1;
    push_pkt(0, 16'hD001, 1, -1, 0);
    wait_log(6, 100);
    if (log_q.size() >= 6)
      for (int k = 0; k < 6; k++)
        chk($sformatf("stall id%0d", k), 64'(log_q[k].id), 64'(exp_id[k]));

    // reset mid-packet, then re-arbitrate from index 0
    #1;
    do_reset();
    push_pkt(2, 16'hE001, 4, -1, 0);
    wait_log(1, 40);
    do_reset();
    push_pkt(3, 16'hF003, 1, -1, 0);
    push_pkt(1, 16'hF001, 1, -1, 0);
    wait_log(2, 40);
    if (log_q.size() >= 2) begin
      chk("post-reset first id", 64'(log_q[0].id), 64'd1);
      chk("post-reset second id", 64'(log_q[1].id), 64'd3);
    end

    // counter wrap
    #1;
    do_reset();
    chk_en = 1'b0;
    @(posedge ACLK);
    #1;
    force dut.pkt_cnt = 16'hFFFF;
    preload = 1'b1;
    @(posedge ACLK);
    #1;
    release dut.pkt_cnt;
    preload = 1'b0;
    chk_en = 1'b1;
    chk("preload PKT_CNT", 64'(PKT_CNT), 64'hFFFF);
    push_pkt(0, 16'h7700, 2, -1, 0);
    wait_log(2, 40);
    repeat (3) @(negedge ACLK);
    #1;
    chk("wrap PKT_CNT", 64'(PKT_CNT), 64'h0000);

    // randomized soak with a reset in the middle
    #1;
    do_reset();
    mt_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge ACLK);
      #1;
      if (c == 1500) do_reset();
      for (int s = 0; s < N; s++) begin
        if (q[s].size() == 0 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            q[s].push_back(mk(16'($urandom), (b == len - 1),
                              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0));
        end
      end
    end
    mt_mode = 0;
    repeat (100) @(negedge ACLK);
    #3;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
